// File: rtl/midori64_dec_core.sv
// Iterative Midori64 decryptor: one decrypt-mode round per cycle, 15 rounds plus a final
// SubCells/whitening step, with valid/ready handshakes on both sides.

module midori64_sbox (
    input  logic [3:0] i_x,
    output logic [3:0] o_y
);
    always_comb begin
        o_y = 4'h0;
        case (i_x)
            4'h0: o_y = 4'hc;  4'h1: o_y = 4'ha;  4'h2: o_y = 4'hd;  4'h3: o_y = 4'h3;
            4'h4: o_y = 4'he;  4'h5: o_y = 4'hb;  4'h6: o_y = 4'hf;  4'h7: o_y = 4'h7;
            4'h8: o_y = 4'h8;  4'h9: o_y = 4'h9;  4'ha: o_y = 4'h1;  4'hb: o_y = 4'h5;
            4'hc: o_y = 4'h0;  4'hd: o_y = 4'h2;  4'he: o_y = 4'h4;  4'hf: o_y = 4'h6;
            default: o_y = 4'h0;
        endcase
    end
endmodule

module midori64_sub_cells (
    input  logic [63:0] i_s,
    output logic [63:0] o_s
);
    for (genvar g = 0; g < 16; g++) begin : g_cell
        midori64_sbox u_sbox (.i_x(i_s[63-4*g -: 4]), .o_y(o_s[63-4*g -: 4]));
    end
endmodule

// Cell g of the output takes input cell MAP[g]; INV selects the inverse permutation.
module midori64_shuffle_cells #(
    parameter bit INV = 1'b0
) (
    input  logic [63:0] i_s,
    output logic [63:0] o_s
);
    localparam logic [63:0] MAP = INV ? 64'h07e952bcf816ad43 : 64'h0a5fe4b193c67d28;
    for (genvar g = 0; g < 16; g++) begin : g_cell
        localparam int SRC = int'(MAP[63-4*g -: 4]);
        assign o_s[63-4*g -: 4] = i_s[63-4*SRC -: 4];
    end
endmodule

module midori64_mix_columns (
    input  logic [63:0] i_s,
    output logic [63:0] o_s
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [3:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = i_s[63-16*c -: 4];
        assign w_a1 = i_s[59-16*c -: 4];
        assign w_a2 = i_s[55-16*c -: 4];
        assign w_a3 = i_s[51-16*c -: 4];
        assign o_s[63-16*c -: 4] = w_a1 ^ w_a2 ^ w_a3;
        assign o_s[59-16*c -: 4] = w_a0 ^ w_a2 ^ w_a3;
        assign o_s[55-16*c -: 4] = w_a0 ^ w_a1 ^ w_a3;
        assign o_s[51-16*c -: 4] = w_a0 ^ w_a1 ^ w_a2;
    end
endmodule

module midori64_round (
    input  logic        i_enc,
    input  logic [63:0] i_rk,
    input  logic [63:0] i_s,
    output logic [63:0] o_s
);
    logic [63:0] w_sb, w_sh, w_enc, w_mc, w_dec;

    midori64_sub_cells                   u_sb   (.i_s(i_s),  .o_s(w_sb));
    midori64_shuffle_cells #(.INV(1'b0)) u_sh   (.i_s(w_sb), .o_s(w_sh));
    midori64_mix_columns                 u_mc_e (.i_s(w_sh), .o_s(w_enc));
    midori64_mix_columns                 u_mc_d (.i_s(w_sb), .o_s(w_mc));
    midori64_shuffle_cells #(.INV(1'b1)) u_ish  (.i_s(w_mc), .o_s(w_dec));

    assign o_s = (i_enc ? w_enc : w_dec) ^ i_rk;
endmodule

module midori64_dec_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [63:0]  ct,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  pt
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL, S_DONE} fsm_t;

    fsm_t        r_fsm;
    logic [63:0] r_state, r_k0, r_k1, r_pt;
    logic [3:0]  r_rnd;
    logic        r_out_valid;

    logic [15:0] w_beta;
    logic [63:0] w_alpha, w_rk, w_rk_mc, w_dk, w_round, w_fin_sb, w_wk;

    // beta(i) bit 15 belongs to cell 0, bit 0 to cell 15
    always_comb begin
        w_beta = 16'h0000;
        case (r_rnd)
            4'd0:  w_beta = 16'h15b3;
            4'd1:  w_beta = 16'h78c0;
            4'd2:  w_beta = 16'ha435;
            4'd3:  w_beta = 16'h6213;
            4'd4:  w_beta = 16'h104f;
            4'd5:  w_beta = 16'hd170;
            4'd6:  w_beta = 16'h0266;
            4'd7:  w_beta = 16'h0bcc;
            4'd8:  w_beta = 16'h9481;
            4'd9:  w_beta = 16'h40b8;
            4'd10: w_beta = 16'h7197;
            4'd11: w_beta = 16'h228e;
            4'd12: w_beta = 16'h5130;
            4'd13: w_beta = 16'hf8ca;
            4'd14: w_beta = 16'hdf90;
            default: w_beta = 16'h0000;
        endcase
    end

    for (genvar j = 0; j < 16; j++) begin : g_alpha
        assign w_alpha[63-4*j -: 4] = {3'b000, w_beta[15-j]};
    end

    assign w_rk = (r_rnd[0] ? r_k1 : r_k0) ^ w_alpha;
    assign w_wk = r_k0 ^ r_k1;

    // Decrypt key schedule: round key pushed through MixColumns then InvShuffleCells
    midori64_mix_columns                 u_dk_mc  (.i_s(w_rk),    .o_s(w_rk_mc));
    midori64_shuffle_cells #(.INV(1'b1)) u_dk_ish (.i_s(w_rk_mc), .o_s(w_dk));

    midori64_round     u_round (.i_enc(1'b0), .i_rk(w_dk), .i_s(r_state), .o_s(w_round));
    midori64_sub_cells u_fin   (.i_s(r_state), .o_s(w_fin_sb));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_k0        <= '0;
            r_k1        <= '0;
            r_rnd       <= '0;
            r_pt        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: if (in_valid) begin
                    r_k0    <= key[127:64];
                    r_k1    <= key[63:0];
                    r_state <= ct ^ key[127:64] ^ key[63:0];
                    r_rnd   <= 4'd14;
                    r_fsm   <= S_RUN;
                end
                S_RUN: begin
                    r_state <= w_round;
                    if (r_rnd == 4'd0) r_fsm <= S_FINAL;
                    else               r_rnd <= r_rnd - 4'd1;
                end
                S_FINAL: begin
                    r_pt        <= w_fin_sb ^ w_wk;
                    r_out_valid <= 1'b1;
                    r_fsm       <= S_DONE;
                end
                S_DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_fsm       <= S_IDLE;
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_fsm == S_IDLE);
    assign out_valid = r_out_valid;
    assign pt        = r_pt;
endmodule

// File: tb/tb_midori64_dec_core.sv
// Bench for midori64_dec_core: known vectors plus random jobs whose ciphertext comes from
// a forward (encrypting) Midori64 model, so the decryptor is checked against its inverse.

module tb_midori64_dec_core;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] key = '0;
    logic [63:0]  ct = '0;
    logic         in_ready, out_valid;
    logic [63:0]  pt;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    localparam logic [127:0] NZK = 128'h687ded3b3c85b3f35b1009863e2a8cbf;
    localparam logic [63:0]  NZC = 64'h66bcdc6270d901cd;
    localparam logic [63:0]  NZP = 64'h42c20fd3b586879e;
    localparam logic [63:0]  ZC  = 64'h3c9cceda2bbd449a;

    localparam logic [3:0]  SB[16]   = '{4'hc, 4'ha, 4'hd, 4'h3, 4'he, 4'hb, 4'hf, 4'h7,
                                         4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6};
    localparam int          SH[16]   = '{0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8};
    localparam logic [15:0] BETA[15] = '{16'h15b3, 16'h78c0, 16'ha435, 16'h6213, 16'h104f,
                                         16'hd170, 16'h0266, 16'h0bcc, 16'h9481, 16'h40b8,
                                         16'h7197, 16'h228e, 16'h5130, 16'hf8ca, 16'hdf90};

    midori64_dec_core dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .key(key), .ct(ct), .out_valid(out_valid), .out_ready(out_ready), .pt(pt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Forward Midori64 encryption over a cell array.
    function automatic logic [63:0] m_enc(input logic [127:0] k, input logic [63:0] p);
        logic [3:0] s[16], t[16], k0[16], k1[16], wk[16], x;
        logic [63:0] r;
        for (int j = 0; j < 16; j++) begin
            k0[j] = k[127-4*j -: 4];
            k1[j] = k[63-4*j -: 4];
            wk[j] = k0[j] ^ k1[j];
            s[j]  = p[63-4*j -: 4] ^ wk[j];
        end
        for (int i = 0; i < 15; i++) begin
            for (int j = 0; j < 16; j++) t[j] = SB[s[SH[j]]];
            for (int c = 0; c < 4; c++) begin
                x = t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                for (int m = 0; m < 4; m++) s[4*c+m] = x ^ t[4*c+m];
            end
            for (int j = 0; j < 16; j++)
                s[j] = s[j] ^ ((i % 2 == 1) ? k1[j] : k0[j]) ^ {3'b000, BETA[i][15-j]};
        end
        for (int j = 0; j < 16; j++) r[63-4*j -: 4] = SB[s[j]] ^ wk[j];
        return r;
    endfunction

    // One job: pokes in_valid/key while busy, holds out_ready low for bp cycles.
    task automatic run_job(input string tag, input logic [127:0] k, input logic [63:0] c,
                           input logic [63:0] exp, input int bp);
        int n;
        @(negedge clk);
        key = k; ct = c; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        chk({tag, " accept"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) break;
            chk({tag, " busy in_ready"}, 64'(in_ready), 64'd0);
            if (n == 2) begin in_valid = 1'b1; ct = {$urandom, $urandom}; end
            if (n == 3) in_valid = 1'b0;
            if (n == 5) key = {$urandom, $urandom, $urandom, $urandom};
        end
        chk({tag, " latency"}, 64'(n), 64'd16);
        chk({tag, " pt"}, pt, exp);
        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            chk({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
            chk({tag, " hold pt"}, pt, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
        chk({tag, " in_ready back"}, 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] rk;
        logic [63:0]  rp;
        int acc[2];
        logic [63:0] outs[2];
        int na, no;
        bit sw;

        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset pt", pt, 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_job("zero", 128'd0, ZC, 64'd0, 0);
        run_job("nz_bp", NZK, NZC, NZP, 10);

        // Reset after the seventh round edge of a fresh job
        @(negedge clk);
        key = NZK; ct = NZC; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst pt", pt, 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_job("after_rst", NZK, NZC, NZP, 1);

        for (int i = 0; i < 8; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom};
            run_job($sformatf("rand%0d", i), rk, m_enc(rk, rp), rp, $urandom_range(0, 3));
        end

        // Back-to-back with in_valid and out_ready held high
        @(negedge clk);
        key = 128'd0; ct = ZC; in_valid = 1'b1; out_ready = 1'b1;
        na = 0; no = 0; sw = 1'b0;
        acc[0] = 0; acc[1] = 0;
        outs[0] = 64'hdeadbeefdeadbeef; outs[1] = 64'hdeadbeefdeadbeef;
        for (int i = 0; i < 80 && no < 2; i++) begin
            if (in_valid && in_ready && na < 2) begin acc[na] = cyc; na++; end
            if (out_valid && no < 2) begin outs[no] = pt; no++; end
            @(negedge clk);
            if (na == 1 && !sw) begin key = NZK; ct = NZC; sw = 1'b1; end
            if (na == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b accepts", 64'(na), 64'd2);
        chk("b2b spacing", 64'(acc[1] - acc[0]), 64'd18);
        chk("b2b pt0", outs[0], 64'd0);
        chk("b2b pt1", outs[1], NZP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/midori64_dec_core.md
# midori64_dec_core

Iterative Midori64 decryption engine with valid/ready handshakes on input and output. It takes a 128-bit key and a 64-bit ciphertext and returns the plaintext. It reuses the shared round module `R` in decrypt mode (`enc=0`: SubCells → MixColumns → InvShuffleCells → ⊕rk). It computes the whitening key and the inverse-transformed round keys internally. It is the receive-side counterpart to the encrypt datapath and consumes that datapath's ciphertext.

## Interface
- Parameters: none. Midori64 dimensions are fixed: 64-bit block, 128-bit key, 15 rounds.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `key`/`ct` valid.
- `in_ready` out 1: block can accept a job; high only in IDLE.
- `key` in 128: K0 = `key[127:64]`, K1 = `key[63:0]`.
- `ct` in 64: ciphertext. Cell 0 = bits [63:60], cell 15 = bits [3:0], matching SubCells/ShuffleCells.
- `out_valid` out 1: `pt` valid.
- `out_ready` in 1: consumer accepts `pt`.
- `pt` out 64: plaintext, registered.

## Operation
- FSM states: IDLE, RUN, FINAL, DONE. Reset state is IDLE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`:
  - Latch K0 and K1.
  - Load `state` = `ct` ⊕ WK, where WK = K0 ⊕ K1.
  - Set `rnd` = 14 (4-bit counter).
  - Go to RUN.
- RUN: each cycle, `state` ← R(enc=0, rk=DK(rnd), `state`).
  - Round key RK(i) = K(i mod 2) ⊕ α(i).
  - α(i) XORs bit j of the 16-bit Midori64 β(i) constant into bit 0 of cell j. The β table is the published 15×16 Midori table, hard-coded.
  - DK(i) = InvShuffleCells(MixColumns(RK(i))), computed combinationally with instances of the shared MixColumns and InvShuffleCells modules.
  - If `rnd`==0, go to FINAL. Otherwise `rnd` ← `rnd`−1.
  - `rnd` never wraps: it is only decremented when nonzero.
- FINAL: `pt` ← SubCells(`state`) ⊕ WK, `out_valid` ← 1, go to DONE.
- DONE: `out_valid`=1 and `pt` stays stable until `out_ready`=1. On that edge, `out_valid` ← 0 and go to IDLE.
- `in_ready`=0 in RUN, FINAL and DONE. `in_valid` is ignored there, and no job is queued.
- `key`/`ct` are sampled only on the accept edge; later changes have no effect.
- Reset (any state, asynchronous):
  - Outputs: `out_valid`=0, `pt`=0.
  - Internal registers: `state`=0, K0=0, K1=0, `rnd`=0.
  - FSM returns to IDLE, so `in_ready`=1 (it is decoded from FSM state).
  - Any in-flight job is discarded with no partial output.

## Timing
- Accept edge is T0. Rounds run on edges T1..T15, with DK(14) at T1 down to DK(0) at T15.
- FINAL at T16: `out_valid` rises after T16, i.e. 16 cycles after the accept cycle.
- If `out_ready` is held high, the out handshake completes at T17 and `in_ready` is high from T17.
- Minimum spacing between accepts is 18 cycles.
- No combinational path from `in_valid` or `out_ready` to any output. `in_ready` and `out_valid` are decoded from FSM state only.
- Critical path: `rnd` → β mux → MixColumns → InvShuffleCells → R → `state`. Single cycle, no multicycle constraint.

## Test plan
- Zero vector: `key`=0, `ct`=0x3c9cceda2bbd449a → `pt`=0x0000000000000000, with `out_valid` rising exactly 16 cycles after accept.
- Nonzero vector: `key`=0x687ded3b3c85b3f35b1009863e2a8cbf, `ct`=0x66bcdc6270d901cd → `pt`=0x42c20fd3b586879e.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `pt` is unchanged and `out_valid` stays 1 throughout. The handshake then completes and `in_ready`=1 on the next cycle.
- Input while busy: pulse `in_valid` with a different `ct` during RUN, then change `key` mid-run → `in_ready`=0 throughout, and the output equals the originally accepted job's plaintext.
- Mid-run reset: assert `rst_n`=0 at T7 → `out_valid`=0 and `pt`=0 immediately, `in_ready`=1. A fresh job with the nonzero vector then returns 0x42c20fd3b586879e.
- Back-to-back: two jobs (zero vector, then nonzero vector) with `in_valid` and `out_ready` held high → accepts 18 cycles apart, correct plaintexts in order.
